// File: rtl/ibfu_dif_pkg.sv
// Shared fixed-point types and the round/saturate helper for the IFFT butterfly.
package ibfu_dif_pkg;

  localparam int FP_BITS   = 16;
  localparam int FRAC_BITS = 14;
  localparam int WIDE_BITS = FP_BITS + 1;
  localparam int PROD_BITS = 2 * FP_BITS + 2;

  typedef struct packed {
    logic signed [FP_BITS-1:0] r;
    logic signed [FP_BITS-1:0] i;
  } complex_t;

  // One guard bit per component so sums, differences and -W.i are exact.
  typedef struct packed {
    logic signed [WIDE_BITS-1:0] r;
    logic signed [WIDE_BITS-1:0] i;
  } complex_wide_t;

  typedef struct packed {
    logic signed [FP_BITS-1:0] value;
    logic                      sat;
  } sat_result_t;

  localparam logic signed [PROD_BITS:0] SAT_HI = (PROD_BITS+1)'(2**(FP_BITS-1) - 1);
  localparam logic signed [PROD_BITS:0] SAT_LO = (PROD_BITS+1)'(-(2**(FP_BITS-1)));
  localparam logic signed [FP_BITS-1:0] OUT_HI = {1'b0, {(FP_BITS-1){1'b1}}};
  localparam logic signed [FP_BITS-1:0] OUT_LO = {1'b1, {(FP_BITS-1){1'b0}}};

  // Round half up by 2^shift, then clamp to the FP_BITS signed range.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic sat_result_t sat_round(input logic signed [PROD_BITS-1:0] value,
                                            input logic [5:0]                  shift);
    logic signed [PROD_BITS:0] ext;
    logic signed [PROD_BITS:0] rnd;
    logic signed [PROD_BITS:0] shifted;
    sat_result_t               res;
    ext = {value[PROD_BITS-1], value};
    rnd = '0;
    if (shift != 6'd0) begin
      rnd[shift - 6'd1] = 1'b1;
    end
    shifted   = (ext + rnd) >>> shift;
    res.value = shifted[FP_BITS-1:0];
    res.sat   = 1'b0;
    if (shifted > SAT_HI) begin
      res.value = OUT_HI;
      res.sat   = 1'b1;
    end else if (shifted < SAT_LO) begin
      res.value = OUT_LO;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ibfu_dif_cmul_conj_wide.sv
// Registered wide complex multiply of diff by an already-conjugated twiddle.
module ibfu_dif_cmul_conj_wide
  import ibfu_dif_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  complex_wide_t               diff,
  input  complex_wide_t               wc,
  output logic signed [PROD_BITS-1:0] pr,
  output logic signed [PROD_BITS-1:0] pi
);

  logic signed [PROD_BITS-1:0] rr_prod;
  logic signed [PROD_BITS-1:0] ii_prod;
  logic signed [PROD_BITS-1:0] ri_prod;
  logic signed [PROD_BITS-1:0] ir_prod;
  logic signed [PROD_BITS-1:0] pr_next;
  logic signed [PROD_BITS-1:0] pi_next;
  logic signed [PROD_BITS-1:0] pr_reg;
  logic signed [PROD_BITS-1:0] pi_reg;

  // Operands are sign-extended before multiplying so no partial product wraps.
  assign rr_prod = PROD_BITS'(diff.r) * PROD_BITS'(wc.r);
  assign ii_prod = PROD_BITS'(diff.i) * PROD_BITS'(wc.i);
  assign ri_prod = PROD_BITS'(diff.r) * PROD_BITS'(wc.i);
  assign ir_prod = PROD_BITS'(diff.i) * PROD_BITS'(wc.r);
  assign pr_next = rr_prod - ii_prod;
  assign pi_next = ri_prod + ir_prod;

  // Product register, advancing only with the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr_reg <= '0;
      pi_reg <= '0;
    end else if (en) begin
      pr_reg <= pr_next;
      pi_reg <= pi_next;
    end
  end

  assign pr = pr_reg;
  assign pi = pi_reg;

endmodule

// File: rtl/ibfu_dif.sv
// Inverse DIF radix-2 butterfly: A' = A + B, B' = (A - B) * conj(W), 4-stage
// pipeline under a single global stall, with sticky saturation flag.
module ibfu_dif
  import ibfu_dif_pkg::*;
#(
  parameter logic SCALE_DEFAULT = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  complex_t A_in,
  input  complex_t B_in,
  input  complex_t W_in,
  input  logic     scale_en,
  output logic     out_valid,
  input  logic     out_ready,
  output complex_t A_out,
  output complex_t B_out,
  output logic     ovf,
  input  logic     ovf_clr
);

  logic adv;

  logic          s1_valid_reg;
  complex_t      s1_a_reg;
  complex_t      s1_b_reg;
  complex_t      s1_w_reg;
  logic          s1_scale_reg;

  complex_wide_t s2_sum_next;
  complex_wide_t s2_diff_next;
  complex_wide_t s2_wc_next;
  logic          s2_valid_reg;
  complex_wide_t s2_sum_reg;
  complex_wide_t s2_diff_reg;
  complex_wide_t s2_wc_reg;
  logic          s2_scale_reg;

  logic          s3_valid_reg;
  complex_wide_t s3_sum_reg;
  logic          s3_scale_reg;
  logic signed [PROD_BITS-1:0] s3_pr;
  logic signed [PROD_BITS-1:0] s3_pi;

  sat_result_t   a_r_sat;
  sat_result_t   a_i_sat;
  sat_result_t   b_r_sat;
  sat_result_t   b_i_sat;
  logic          any_sat;

  logic          out_valid_reg;
  complex_t      a_out_reg;
  complex_t      b_out_reg;
  logic          ovf_reg;

  // A held result blocks every stage; out_ready is meaningless without a result.
  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv;

  // Guard-bit sum/difference and exact conjugate of the twiddle.
  always_comb begin
    s2_sum_next.r  = WIDE_BITS'(s1_a_reg.r) + WIDE_BITS'(s1_b_reg.r);
    s2_sum_next.i  = WIDE_BITS'(s1_a_reg.i) + WIDE_BITS'(s1_b_reg.i);
    s2_diff_next.r = WIDE_BITS'(s1_a_reg.r) - WIDE_BITS'(s1_b_reg.r);
    s2_diff_next.i = WIDE_BITS'(s1_a_reg.i) - WIDE_BITS'(s1_b_reg.i);
    s2_wc_next.r   = WIDE_BITS'(s1_w_reg.r);
    s2_wc_next.i   = -WIDE_BITS'(s1_w_reg.i);
  end

  // Stages S1..S3 shift together; bubbles travel through with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_w_reg     <= '0;
      s1_scale_reg <= SCALE_DEFAULT;
      s2_valid_reg <= 1'b0;
      s2_sum_reg   <= '0;
      s2_diff_reg  <= '0;
      s2_wc_reg    <= '0;
      s2_scale_reg <= SCALE_DEFAULT;
      s3_valid_reg <= 1'b0;
      s3_sum_reg   <= '0;
      s3_scale_reg <= SCALE_DEFAULT;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s1_a_reg     <= A_in;
      s1_b_reg     <= B_in;
      s1_w_reg     <= W_in;
      s1_scale_reg <= scale_en;
      s2_valid_reg <= s1_valid_reg;
      s2_sum_reg   <= s2_sum_next;
      s2_diff_reg  <= s2_diff_next;
      s2_wc_reg    <= s2_wc_next;
      s2_scale_reg <= s1_scale_reg;
      s3_valid_reg <= s2_valid_reg;
      s3_sum_reg   <= s2_sum_reg;
      s3_scale_reg <= s2_scale_reg;
    end
  end

  ibfu_dif_cmul_conj_wide u_cmul (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .diff (s2_diff_reg),
    .wc   (s2_wc_reg),
    .pr   (s3_pr),
    .pi   (s3_pi)
  );

  // Scaling folds into the rounding shift: one extra bit on both paths.
  always_comb begin
    a_r_sat = sat_round(PROD_BITS'(s3_sum_reg.r), {5'd0, s3_scale_reg});
    a_i_sat = sat_round(PROD_BITS'(s3_sum_reg.i), {5'd0, s3_scale_reg});
    b_r_sat = sat_round(s3_pr, 6'(FRAC_BITS) + {5'd0, s3_scale_reg});
    b_i_sat = sat_round(s3_pi, 6'(FRAC_BITS) + {5'd0, s3_scale_reg});
    any_sat = a_r_sat.sat || a_i_sat.sat || b_r_sat.sat || b_i_sat.sat;
  end

  // Output stage and sticky overflow; a set on the same edge beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      a_out_reg     <= '0;
      b_out_reg     <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      if (adv) begin
        out_valid_reg <= s3_valid_reg;
        a_out_reg.r   <= a_r_sat.value;
        a_out_reg.i   <= a_i_sat.value;
        b_out_reg.r   <= b_r_sat.value;
        b_out_reg.i   <= b_i_sat.value;
      end
      if (adv && s3_valid_reg && any_sat) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign A_out     = a_out_reg;
  assign B_out     = b_out_reg;
  assign ovf       = ovf_reg;

endmodule
